// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// Holds the default datapath width, the major opcode constants, the ALUOp
// encodings produced by the main decoder and the packed control bundle that
// travels from ID into EX.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_R_W    = 7'b0111011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } aluop_e;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
// Flags the ID instruction when the load currently in EX writes a register
// that ID reads before the load data is available.
// Ports:
//   i_ex_valid, i_ex_memread, i_ex_rd : load candidate in EX
//   i_id_valid, i_id_rs1, i_id_rs2    : consumer candidate in ID
//   i_id_alusrc, i_id_memwrite        : decide whether rs2 is really read
//   o_load_use                        : hazard flag
module load_use_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_alusrc,
    input  logic       i_id_memwrite,
    output logic       o_load_use
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_rs2_used;

    assign w_rs1_match = (i_ex_rd == i_id_rs1);
    assign w_rs2_match = (i_ex_rd == i_id_rs2);
    // rs2 is a real source for register-register ops and for stores (store
    // data); an immediate-form ALU op only carries an rs2-shaped imm field.
    assign w_rs2_used  = !i_id_alusrc | i_id_memwrite;

    // A load into x0 never produces a value anyone waits for.
    assign o_load_use = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0) & i_id_valid
                      & (w_rs1_match | (w_rs2_match & w_rs2_used));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion.
// Per edge the priority is flush > hold > bubble > load. Flush and bubble
// kill the control bundle so an invalid EX slot can never write state.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   id_*                            : decoded instruction from ID
//   ex_flush, ex_stall              : wrong-path kill, downstream hold
//   id_ready, load_use              : combinational handshake / hazard
//   ex_*                            : registered instruction in EX
//   bubble_cnt                      : saturating count of load-use bubbles
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic            id_alusrc,
    input  logic            id_memtoreg,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_branch,
    input  logic [1:0]      id_aluop,
    input  logic            ex_flush,
    input  logic            ex_stall,
    output logic            id_ready,
    output logic            load_use,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_5,
    output logic            ex_alusrc,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic [1:0]      ex_aluop,
    output logic [15:0]     bubble_cnt
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    ctrl_t            w_id_ctrl;
    logic             w_load_use;

    logic             r_ex_valid;
    ctrl_t            r_ex_ctrl;
    logic [XLEN-1:0]  r_ex_pc;
    logic [XLEN-1:0]  r_ex_rs1_data;
    logic [XLEN-1:0]  r_ex_rs2_data;
    logic [XLEN-1:0]  r_ex_imm;
    logic [4:0]       r_ex_rs1;
    logic [4:0]       r_ex_rs2;
    logic [4:0]       r_ex_rd;
    logic [2:0]       r_ex_funct3;
    logic             r_ex_funct7_5;
    logic [15:0]      r_bubble_cnt;

    assign w_id_ctrl = '{alusrc:   id_alusrc,
                         memtoreg: id_memtoreg,
                         regwrite: id_regwrite,
                         memread:  id_memread,
                         memwrite: id_memwrite,
                         branch:   id_branch,
                         aluop:    id_aluop};

    load_use_detect u_load_use_detect (
        .i_ex_valid    (r_ex_valid),
        .i_ex_memread  (r_ex_ctrl.memread),
        .i_ex_rd       (r_ex_rd),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_alusrc   (id_alusrc),
        .i_id_memwrite (id_memwrite),
        .o_load_use    (w_load_use)
    );

    assign load_use = w_load_use;
    assign id_ready = !ex_stall & !w_load_use & !ex_flush;

    // ID -> EX register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_funct3   <= '0;
            r_ex_funct7_5 <= 1'b0;
            r_bubble_cnt  <= '0;
        end else if (ex_flush) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (ex_stall) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_load_use) begin
            // Bubble: the consumer stays in ID and enters on the next edge.
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_bubble_cnt <= sat_inc16(r_bubble_cnt);
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_ctrl     <= id_valid ? w_id_ctrl : '0;
            r_ex_pc       <= id_pc;
            r_ex_rs1_data <= id_rs1_data;
            r_ex_rs2_data <= id_rs2_data;
            r_ex_imm      <= id_imm;
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
            r_ex_rd       <= id_rd;
            r_ex_funct3   <= id_funct3;
            r_ex_funct7_5 <= id_funct7_5;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_rs1_data = r_ex_rs1_data;
    assign ex_rs2_data = r_ex_rs2_data;
    assign ex_imm      = r_ex_imm;
    assign ex_rs1      = r_ex_rs1;
    assign ex_rs2      = r_ex_rs2;
    assign ex_rd       = r_ex_rd;
    assign ex_funct3   = r_ex_funct3;
    assign ex_funct7_5 = r_ex_funct7_5;
    assign ex_alusrc   = r_ex_ctrl.alusrc;
    assign ex_memtoreg = r_ex_ctrl.memtoreg;
    assign ex_regwrite = r_ex_ctrl.regwrite;
    assign ex_memread  = r_ex_ctrl.memread;
    assign ex_memwrite = r_ex_ctrl.memwrite;
    assign ex_branch   = r_ex_ctrl.branch;
    assign ex_aluop    = r_ex_ctrl.aluop;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_id_ex_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic            id_funct7_5;
    logic            id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
    logic [1:0]      id_aluop;
    logic            ex_flush, ex_stall;
    logic            id_ready, load_use, ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_funct7_5;
    logic            ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0]      ex_aluop;
    logic [15:0]     bubble_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7_5(id_funct7_5), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_aluop(id_aluop), .ex_flush(ex_flush), .ex_stall(ex_stall),
        .id_ready(id_ready), .load_use(load_use), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7_5(ex_funct7_5), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_aluop(ex_aluop), .bubble_cnt(bubble_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Control bundle as one byte: alusrc memtoreg regwrite memread memwrite branch aluop[1:0]
    localparam logic [7:0] C_LW   = 8'b1111_0000;
    localparam logic [7:0] C_ADD  = 8'b0010_0010;
    localparam logic [7:0] C_ADDI = 8'b1010_0000;
    localparam logic [7:0] C_SW   = 8'b1000_1000;
    localparam logic [7:0] C_BEQ  = 8'b0000_0101;

    // Behavioural model of what EX must hold.
    logic            m_valid;
    logic [7:0]      m_ctl;
    logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [2:0]      m_f3;
    logic            m_f7;
    logic [15:0]     m_cnt;

    function automatic logic [7:0] id_ctl();
        return {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop};
    endfunction

    function automatic logic [7:0] ex_ctl();
        return {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop};
    endfunction

    // The consumer must wait if EX holds a real load into a nonzero register
    // that ID reads (rs2 counts only for reg-reg ops and stores).
    function automatic logic model_lu();
        logic reads_rs2;
        reads_rs2 = !id_alusrc || id_memwrite;
        return m_valid && m_ctl[4] && (m_rd != 5'd0) && id_valid &&
               ((m_rd == id_rs1) || ((m_rd == id_rs2) && reads_rs2));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_valid = 0; m_ctl = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (ex_flush) begin
            m_valid = 0; m_ctl = 0;
        end else if (ex_stall) begin
            m_valid = m_valid;
        end else if (model_lu()) begin
            m_valid = 0; m_ctl = 0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_valid = id_valid;
            m_ctl   = id_valid ? id_ctl() : 8'h00;
            m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3; m_f7 = id_funct7_5;
        end
    endtask

    task automatic check_regs();
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_ctl", ex_ctl(), m_ctl);
        chk("bubble_cnt", bubble_cnt, m_cnt);
        chk("invariant", {ex_regwrite, ex_memread, ex_memwrite, ex_branch} & {4{~ex_valid}}, 0);
        if (m_valid) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rs1_data", ex_rs1_data, m_rs1d);
            chk("ex_rs2_data", ex_rs2_data, m_rs2d);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m_rs1, m_rs2, m_rd});
            chk("ex_funct", {ex_funct3, ex_funct7_5}, {m_f3, m_f7});
        end
    endtask

    // Let combinational outputs settle after an input change and check them.
    task automatic settle();
        #1;
        chk("load_use", load_use, model_lu());
        chk("id_ready", id_ready, !ex_stall && !model_lu() && !ex_flush);
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [7:0] ctl, input logic [63:0] pc);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_pc = pc;
        {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop} = ctl;
        id_rs1_data = {$urandom, $urandom}; id_rs2_data = {$urandom, $urandom};
        id_imm = {$urandom, $urandom}; id_funct3 = 3'($urandom); id_funct7_5 = 1'($urandom);
    endtask

    initial begin
        rst_n = 0; ex_flush = 0; ex_stall = 0;
        set_id(0, 0, 0, 0, 8'h00, 64'h0);
        m_reset();
        @(negedge clk); @(negedge clk);
        check_regs();
        chk("reset_valid", ex_valid, 0);
        chk("reset_cnt", bubble_cnt, 0);
        rst_n = 1;

        // lw x5 enters EX, then add x7,x5,x6 must be bubbled once
        set_id(1, 5'd1, 5'd0, 5'd5, C_LW, 64'h100); settle(); edge_step();
        set_id(1, 5'd5, 5'd6, 5'd7, C_ADD, 64'h104); settle();
        chk("lu_add", load_use, 1);
        chk("ready_add", id_ready, 0);
        edge_step();
        chk("bubble_valid", ex_valid, 0);
        chk("bubble_cnt1", bubble_cnt, 1);
        settle(); edge_step();
        chk("add_in_ex", {ex_valid, ex_rd, ex_pc[15:0]}, {1'b1, 5'd7, 16'h0104});

        // load into x0 is never a hazard
        set_id(1, 5'd2, 5'd0, 5'd0, C_LW, 64'h108); settle(); edge_step();
        set_id(1, 5'd0, 5'd6, 5'd8, C_ADD, 64'h10C); settle();
        chk("lu_x0", load_use, 0);
        edge_step();
        chk("x0_add_in_ex", {ex_valid, ex_rd}, {1'b1, 5'd8});

        // addi's rs2 field is an immediate; sw's rs2 is real store data
        set_id(1, 5'd3, 5'd0, 5'd7, C_LW, 64'h110); settle(); edge_step();
        set_id(1, 5'd1, 5'd7, 5'd9, C_ADDI, 64'h114); settle();
        chk("lu_addi", load_use, 0);
        set_id(1, 5'd2, 5'd7, 5'd0, C_SW, 64'h118); settle();
        chk("lu_sw", load_use, 1);
        edge_step();
        chk("sw_bubble_cnt", bubble_cnt, 2);
        settle(); edge_step();
        chk("sw_in_ex", {ex_valid, ex_memwrite, ex_pc[15:0]}, {2'b11, 16'h0118});

        // flush beats stall and bubble
        set_id(1, 5'd1, 5'd0, 5'd5, C_LW, 64'h11C); settle(); edge_step();
        set_id(1, 5'd5, 5'd6, 5'd7, C_ADD, 64'h120);
        ex_flush = 1; ex_stall = 1; settle();
        chk("lu_under_flush", load_use, 1);
        edge_step();
        chk("flush_ctl", {ex_valid, ex_ctl()}, 9'h000);
        chk("flush_cnt", bubble_cnt, 2);
        ex_flush = 0; ex_stall = 0;

        // beq held for three stalled cycles
        set_id(1, 5'd3, 5'd4, 5'd0, C_BEQ, 64'h200); settle(); edge_step();
        set_id(1, 5'd1, 5'd2, 5'd3, C_ADD, 64'h204);
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_ready", id_ready, 0);
            edge_step();
            chk("stall_frozen", {ex_valid, ex_branch, ex_pc[15:0]}, {2'b11, 16'h0200});
        end
        ex_stall = 0; settle(); edge_step();
        chk("stall_release", {ex_valid, ex_pc[15:0]}, {1'b1, 16'h0204});

        // saturation near the top of the counter
        force dut.r_bubble_cnt = 16'hFFFE;
        #1 release dut.r_bubble_cnt;
        m_cnt = 16'hFFFE;
        set_id(1, 5'd1, 5'd0, 5'd5, C_LW, 64'h300); settle(); edge_step();
        set_id(1, 5'd5, 5'd0, 5'd5, C_LW, 64'h304); settle(); edge_step();
        chk("sat_first", bubble_cnt, 16'hFFFF);
        settle(); edge_step();
        settle(); edge_step();
        chk("sat_stay", bubble_cnt, 16'hFFFF);

        // asynchronous reset mid-cycle, during a hold
        ex_stall = 1;
        #2 rst_n = 0;
        #1;
        chk("async_rst", {ex_valid, ex_ctl(), ex_rd, ex_pc}, 0);
        chk("async_rst_cnt", bubble_cnt, 0);
        m_reset();
        #1 rst_n = 1;
        ex_stall = 0;
        set_id(0, 0, 0, 0, 8'h00, 64'h0);
        settle(); edge_step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            id_valid    = ($urandom_range(0, 9) != 0);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 7));
            id_pc       = {$urandom, $urandom};
            id_rs1_data = {$urandom, $urandom};
            id_rs2_data = {$urandom, $urandom};
            id_imm      = {$urandom, $urandom};
            id_funct3   = 3'($urandom);
            id_funct7_5 = 1'($urandom);
            {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop}
                = 8'($urandom);
            ex_flush = ($urandom_range(0, 9) == 0);
            ex_stall = ($urandom_range(0, 6) == 0);
            settle();
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
